// File: rtl/matmul_sequencer.sv
// matmul_sequencer: drives a single-MAC accumulator to compute C = A x B.
// Row-major, unsigned 32-bit operands, sums wrap modulo 2^32. Each product
// term costs RD, LAT, MAC, WAIT; each C element adds CLR, SETTLE and WRITE.
module matmul_sequencer #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_n,
  output logic              busy,
  output logic              done,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_rdata,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_rdata,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_addr,
  output logic [31:0]       c_wdata,
  output logic [31:0]       mac_a,
  output logic [31:0]       mac_b,
  output logic              mac_add,
  output logic              mac_clear,
  input  logic [31:0]       mac_accum_out,
  input  logic              mac_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_RD, S_LAT, S_MAC, S_WAIT, S_SETTLE, S_WRITE, S_DONE
  } state_e;

  // Wide enough that row*stride+col never overflows before truncation.
  localparam int FULL_W = 2 * DIM_W + ADDR_W + 1;

  state_e state_q, state_d;
  logic [DIM_W-1:0] m_q, m_d, kd_q, kd_d, n_q, n_d;
  logic [DIM_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [31:0]      mac_a_q, mac_a_d, mac_b_q, mac_b_d;

  // Row-major linear address row*stride+col, truncated to the memory width.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [DIM_W-1:0] row,
                                                  input logic [DIM_W-1:0] stride,
                                                  input logic [DIM_W-1:0] col);
    logic [FULL_W-1:0] full;
    full = FULL_W'(row) * FULL_W'(stride) + FULL_W'(col);
    return full[ADDR_W-1:0];
  endfunction

  assign mac_a = mac_a_q;
  assign mac_b = mac_b_q;
  assign busy  = (state_q != S_IDLE);

  // State, latched dimensions, loop counters and MAC operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      kd_q    <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      mac_a_q <= '0;
      mac_b_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      kd_q    <= kd_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
    end
  end

  // Next-state, counter updates and per-state strobes/addresses.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    kd_d      = kd_q;
    n_d       = n_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    done      = 1'b0;
    a_rd_en   = 1'b0;
    b_rd_en   = 1'b0;
    c_wr_en   = 1'b0;
    a_addr    = '0;
    b_addr    = '0;
    c_addr    = '0;
    c_wdata   = '0;
    mac_add   = 1'b0;
    mac_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d  = dim_m;
          kd_d = dim_k;
          n_d  = dim_n;
          i_d  = '0;
          j_d  = '0;
          k_d  = '0;
          if (dim_m == '0 || dim_k == '0 || dim_n == '0) state_d = S_DONE;
          else                                             state_d = S_CLR;
        end
      end
      S_CLR: begin
        mac_clear = 1'b1;
        k_d       = '0;
        state_d   = S_RD;
      end
      S_RD: begin
        a_rd_en = 1'b1;
        b_rd_en = 1'b1;
        a_addr  = lin_addr(i_q, kd_q, k_q);
        b_addr  = lin_addr(k_q, n_q, j_q);
        state_d = S_LAT;
      end
      S_LAT: begin
        mac_a_d = a_rdata;
        mac_b_d = b_rdata;
        state_d = S_MAC;
      end
      S_MAC: begin
        mac_add = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mac_done) begin
          if (k_q == kd_q - DIM_W'(1)) begin
            state_d = S_SETTLE;
          end else begin
            k_d     = k_q + DIM_W'(1);
            state_d = S_RD;
          end
        end
      end
      // mac_accum_out lags the accumulator by a cycle; let it catch up.
      S_SETTLE: state_d = S_WRITE;
      S_WRITE: begin
        c_wr_en = 1'b1;
        c_addr  = lin_addr(i_q, n_q, j_q);
        c_wdata = mac_accum_out;
        if (j_q == n_q - DIM_W'(1)) begin
          j_d = '0;
          i_d = i_q + DIM_W'(1);
          if (i_q == m_q - DIM_W'(1)) state_d = S_DONE;
          else                        state_d = S_CLR;
        end else begin
          j_d     = j_q + DIM_W'(1);
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: operand memories, a behavioural MAC with
// configurable done latency, a scoreboard of expected C writes and a
// reference product computed with plain nested loops.
module tb_matmul_sequencer;
  localparam int DIM_W  = 8;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  dim_m = '0, dim_k = '0, dim_n = '0;
  logic              busy, done, a_rd_en, b_rd_en, c_wr_en, mac_add, mac_clear;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [31:0]       a_rdata, b_rdata, c_wdata, mac_a, mac_b, mac_accum_out;
  logic              mac_done;

  always #5 clk = ~clk;

  matmul_sequencer #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
    .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wdata(c_wdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_add(mac_add), .mac_clear(mac_clear),
    .mac_accum_out(mac_accum_out), .mac_done(mac_done)
  );

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  wr_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_wr = 0, n_done = 0, n_add = 0, n_clr = 0, n_rd = 0, viol = 0;
  int last_add = -100;
  logic prev_add_m = 1'b0;

  logic [31:0] a_mem [0:255];
  logic [31:0] b_mem [0:255];
  int   mac_lat = 0;
  bit   spur_en = 1'b0;
  logic [31:0] acc;
  logic prev_add;
  int   dly;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories: one-cycle read latency, junk when not read.
  always @(posedge clk) begin
    if (a_rd_en) a_rdata <= a_mem[a_addr[7:0]]; else a_rdata <= $urandom();
    if (b_rd_en) b_rdata <= b_mem[b_addr[7:0]]; else b_rdata <= $urandom();
  end

  // MAC: rising-edge add, clear, registered output, done after mac_lat extra cycles.
  always @(posedge clk) begin
    if (reset) begin
      acc <= '0; mac_accum_out <= '0; prev_add <= 1'b0; dly <= 0; mac_done <= 1'b0;
    end else begin
      prev_add      <= mac_add;
      mac_accum_out <= acc;
      mac_done      <= 1'b0;
      if (mac_clear) acc <= '0;
      else if (mac_add && !prev_add) acc <= acc + mac_a * mac_b;
      if (mac_add && !prev_add) begin
        if (mac_lat == 0) mac_done <= 1'b1; else dly <= mac_lat;
      end else if (dly > 0) begin
        dly <= dly - 1;
        if (dly == 1) mac_done <= 1'b1;
      end else if (spur_en && mac_clear) begin
        mac_done <= 1'b1;  // stray pulse landing in RD, must be ignored
      end
    end
  end

  // Monitor: scoreboard compare on every C write, activity and protocol tallies.
  always @(negedge clk) begin
    wr_t e;
    if (c_wr_en === 1'b1) begin
      n_wr++;
      if (sb_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", c_addr, c_wdata);
      end else begin
        e = sb_q.pop_front();
        check("c_addr", 64'(c_addr), 64'(e.addr));
        check("c_wdata", 64'(c_wdata), 64'(e.data));
      end
    end
    if (done === 1'b1) n_done++;
    if (a_rd_en === 1'b1) n_rd++;
    if (mac_clear === 1'b1) n_clr++;
    if (mac_add === 1'b1) begin
      n_add++;
      if (mac_clear === 1'b1) viol++;
      if (prev_add_m) viol++;
      else if (cyc - last_add < 4) viol++;
      last_add = cyc;
    end
    prev_add_m = (mac_add === 1'b1);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, a_rd_en, b_rd_en, c_wr_en, mac_add, mac_clear}), 64'd0);
    check({tag, "_addr"}, 64'({a_addr, b_addr, c_addr}), 64'd0);
    check({tag, "_mac_ops"}, {mac_a, mac_b}, 64'd0);
    check({tag, "_wdata"}, 64'(c_wdata), 64'd0);
  endtask

  task automatic push(input int addr, input logic [31:0] data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Fill memories randomly and push the reference product into the scoreboard.
  task automatic load_random(input int m, input int k, input int n, input bit big);
    logic [31:0] sum;
    for (int x = 0; x < m * k; x++) a_mem[x] = big ? $urandom() : 32'($urandom_range(0, 15));
    for (int x = 0; x < k * n; x++) b_mem[x] = big ? $urandom() : 32'($urandom_range(0, 15));
    if (m == 0 || k == 0 || n == 0) return;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        sum = '0;
        for (int kk = 0; kk < k; kk++) sum = sum + a_mem[i * k + kk] * b_mem[kk * n + j];
        push(i * n + j, sum);
      end
  endtask

  task automatic run_job(input int m, input int k, input int n, input int lat,
                         input bit mid_start, input bit spur);
    int st, got, busy_cnt, exp_lat, terms, elems;
    int wr0, done0, add0, clr0, rd0;
    bit seen;
    mac_lat = lat; spur_en = spur;
    wr0 = n_wr; done0 = n_done; add0 = n_add; clr0 = n_clr; rd0 = n_rd;
    elems = (m == 0 || k == 0 || n == 0) ? 0 : m * n;
    terms = elems * k;
    exp_lat = (elems == 0) ? 1 : m * n * (k * (4 + lat) + 3) + 1;
    @(posedge clk); #1;
    dim_m = DIM_W'(m); dim_k = DIM_W'(k); dim_n = DIM_W'(n); start = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    dim_m = DIM_W'($urandom()); dim_k = DIM_W'($urandom()); dim_n = DIM_W'($urandom());
    busy_cnt = 0; got = -1; seen = 1'b0;
    for (int t = 0; t < 5000 && !seen; t++) begin
      @(negedge clk); #1;
      if (mid_start && t == 10) begin
        start = 1'b1; dim_m = 8'd3; dim_k = 8'd3; dim_n = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin got = cyc - st; seen = 1'b1; end
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout actual=no done required=done within 5000 cycles");
    end
    check("done_latency", 64'(got), 64'(exp_lat));
    check("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
    repeat (3) begin @(negedge clk); #1; end
    check("idle_after_done", 64'(busy), 64'd0);
    check("done_pulses", 64'(n_done - done0), 64'd1);
    check("write_count", 64'(n_wr - wr0), 64'(elems));
    check("mac_add_count", 64'(n_add - add0), 64'(terms));
    check("mac_clear_count", 64'(n_clr - clr0), 64'(elems));
    check("read_count", 64'(n_rd - rd0), 64'(terms));
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic load_2x2();
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
    b_mem[0] = 5; b_mem[1] = 6; b_mem[2] = 7; b_mem[3] = 8;
    push(0, 32'd19); push(1, 32'd22); push(2, 32'd43); push(3, 32'd50);
  endtask

  initial begin
    int t, wr0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    load_2x2();
    run_job(2, 2, 2, 0, 1'b0, 1'b0);

    a_mem[0] = 2; a_mem[1] = 3; a_mem[2] = 4;
    b_mem[0] = 5; b_mem[1] = 6; b_mem[2] = 7;
    push(0, 32'd56);
    run_job(1, 3, 1, 0, 1'b0, 1'b0);

    run_job(2, 0, 2, 0, 1'b0, 1'b0);

    a_mem[0] = 32'hFFFF_FFFF; b_mem[0] = 32'hFFFF_FFFF;
    push(0, 32'h0000_0001);
    run_job(1, 1, 1, 0, 1'b0, 1'b0);

    load_2x2();
    run_job(2, 2, 2, 0, 1'b1, 1'b0);

    // Abort the 2x2 job during WAIT of the third element.
    load_2x2();
    mac_lat = 0; spur_en = 1'b0;
    wr0 = n_wr;
    @(posedge clk); #1;
    dim_m = 8'd2; dim_k = 8'd2; dim_n = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (n_wr < wr0 + 2 && t < 2000) begin @(negedge clk); #1; t++; end
    while (mac_add !== 1'b1 && t < 2000) begin @(negedge clk); #1; t++; end
    if (t >= 2000) begin
      n_checks++; n_errors++;
      $display("FAIL abort_setup_timeout actual=%0d writes required=2 writes then mac_add", n_wr - wr0);
    end
    check("writes_before_abort", 64'(n_wr - wr0), 64'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    check("pending_at_abort", 64'(sb_q.size()), 64'd2);
    sb_q.delete();
    reset = 1'b0;
    wr0 = n_wr;
    repeat (40) @(posedge clk);
    #1;
    check("no_write_after_abort", 64'(n_wr - wr0), 64'd0);
    load_2x2();
    run_job(2, 2, 2, 0, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int m, k, n;
      m = $urandom_range(1, 4);
      k = $urandom_range(0, 4);
      n = $urandom_range(1, 4);
      load_random(m, k, n, 1'($urandom_range(0, 1)));
      run_job(m, k, n, $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
    end

    check("protocol_violations", 64'(viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
